// File: rtl/pcie_read_req_arbiter_pkg.sv
// pcie_read_pkg: request field layout and tdest helper shared by the read-request arbiter
package pcie_read_pkg;
  localparam int REQ_WIDTH = 128;
  localparam int LEN_LSB = 0;
  localparam int LEN_WIDTH = 16;
  localparam int CORE_TAG_LSB = 16;
  localparam int CORE_TAG_WIDTH = 16;
  localparam int CORE_ADDR_LSB = 32;
  localparam int CORE_ADDR_WIDTH = 32;
  localparam int HOST_ADDR_LSB = 64;
  localparam int HOST_ADDR_WIDTH = 64;
  typedef struct packed {
    logic [HOST_ADDR_WIDTH-1:0] host_addr;
    logic [CORE_ADDR_WIDTH-1:0] core_addr;
    logic [CORE_TAG_WIDTH-1:0] core_tag;
    logic [LEN_WIDTH-1:0] len;
  } req_t;
  function automatic int unsigned tdest_core(input logic [31:0] tdest, input int tag_w, input int core_w);
    return (tdest >> (tag_w - core_w)) & ((32'd1 << core_w) - 32'd1);
  endfunction
endpackage

// File: rtl/pcie_read_req_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin select, first request at or above ptr, wrapping to 0
module rr_arbiter #(
  parameter int N = 16,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [N-1:0] masked, pick;
  always_comb begin
    masked = req & ({N{1'b1}} << ptr);
    pick = (masked != '0) ? masked : req;
    gnt = pick & (~pick + N'(1));
    idx = '0;
    for (int i = 0; i < N; i++) idx = gnt[i] ? W'(i) : idx;
    any = req != '0;
  end
endmodule

// File: rtl/pcie_read_req_arbiter.sv
// pcie_read_req_arbiter: credit-limited round-robin sharing of the engine request channel across cores
module pcie_read_req_arbiter
  import pcie_read_pkg::*;
#(
  parameter int CORE_COUNT = 16,
  parameter int CORE_WIDTH = $clog2(CORE_COUNT),
  parameter int AXIS_TAG_WIDTH = 9,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CREDIT_WIDTH = $clog2(MAX_OUTSTANDING + 1),
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                            pcie_clk,
  input  logic                            pcie_rst_n,
  input  logic                            enable,
  input  logic [CORE_COUNT*REQ_WIDTH-1:0] req_tdata,
  input  logic [CORE_COUNT-1:0]           req_tvalid,
  output logic [CORE_COUNT-1:0]           req_tready,
  output logic [REQ_WIDTH-1:0]            m_tdata,
  output logic [CORE_WIDTH-1:0]           m_tuser,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  input  logic [AXIS_TAG_WIDTH-1:0]       rx_tdest,
  input  logic                            rx_tvalid,
  input  logic                            rx_tready,
  input  logic                            rx_tlast,
  output logic [CORE_COUNT-1:0]           core_busy,
  output logic [DROP_CNT_WIDTH-1:0]       drop_count,
  output logic                            credit_underflow
);
  req_t req_a [CORE_COUNT];
  req_t g_req, m_tdata_q, m_tdata_d;
  logic [CREDIT_WIDTH-1:0] credit_q [CORE_COUNT];
  logic [CREDIT_WIDTH-1:0] credit_d [CORE_COUNT];
  logic [CORE_COUNT-1:0] eligible, gnt, inc, dec, core_busy_q, core_busy_d;
  logic [CORE_WIDTH-1:0] g, c, ptr_q, ptr_d, m_tuser_q, m_tuser_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic any, load, grant, fwd, rx_fire;
  logic m_tvalid_q, m_tvalid_d, credit_underflow_q, credit_underflow_d;

  always_comb begin
    for (int i = 0; i < CORE_COUNT; i++) begin
      req_a[i] = req_t'(req_tdata[i*REQ_WIDTH +: REQ_WIDTH]);
      eligible[i] = enable && req_tvalid[i] &&
                    (credit_q[i] < CREDIT_WIDTH'(MAX_OUTSTANDING) || req_a[i].len == '0);
    end
  end

  rr_arbiter #(.N(CORE_COUNT), .W(CORE_WIDTH)) u_arb (
    .req(eligible),
    .ptr(ptr_q),
    .gnt(gnt),
    .idx(g),
    .any(any)
  );

  assign load = !m_tvalid_q || m_tready;
  assign grant = load && any && pcie_rst_n;
  assign g_req = req_a[g];
  assign fwd = grant && g_req.len != '0;
  assign req_tready = grant ? gnt : '0;
  assign rx_fire = rx_tvalid && rx_tready && rx_tlast;
  assign c = CORE_WIDTH'(tdest_core(32'(rx_tdest), AXIS_TAG_WIDTH, CORE_WIDTH));

  always_comb begin
    m_tvalid_d = load ? fwd : m_tvalid_q;
    m_tdata_d = fwd ? g_req : m_tdata_q;
    m_tuser_d = fwd ? g : m_tuser_q;
    ptr_d = grant ? ((g == CORE_WIDTH'(CORE_COUNT - 1)) ? '0 : g + CORE_WIDTH'(1)) : ptr_q;
    drop_d = (grant && !fwd && drop_q != '1) ? drop_q + DROP_CNT_WIDTH'(1) : drop_q;
    credit_underflow_d = credit_underflow_q || (rx_fire && credit_q[c] == '0);
    inc = fwd ? gnt : '0;
    dec = rx_fire ? CORE_COUNT'(1) << c : '0;
    for (int i = 0; i < CORE_COUNT; i++) begin
      credit_d[i] = (inc[i] && !dec[i]) ? credit_q[i] + CREDIT_WIDTH'(1) :
                    (dec[i] && !inc[i] && credit_q[i] != '0) ? credit_q[i] - CREDIT_WIDTH'(1) :
                    credit_q[i];
      core_busy_d[i] = credit_d[i] == CREDIT_WIDTH'(MAX_OUTSTANDING);
    end
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      m_tvalid_q <= 1'b0;
      m_tdata_q <= '0;
      m_tuser_q <= '0;
      ptr_q <= '0;
      drop_q <= '0;
      credit_underflow_q <= 1'b0;
      core_busy_q <= '0;
      for (int i = 0; i < CORE_COUNT; i++) credit_q[i] <= '0;
    end else begin
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q <= m_tdata_d;
      m_tuser_q <= m_tuser_d;
      ptr_q <= ptr_d;
      drop_q <= drop_d;
      credit_underflow_q <= credit_underflow_d;
      core_busy_q <= core_busy_d;
      for (int i = 0; i < CORE_COUNT; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata = m_tdata_q;
  assign m_tuser = m_tuser_q;
  assign core_busy = core_busy_q;
  assign drop_count = drop_q;
  assign credit_underflow = credit_underflow_q;
endmodule

// File: tb/tb_pcie_read_req_arbiter.sv
// tb_pcie_read_req_arbiter: directed scenarios plus randomized traffic against a queue-free reference model
module tb_pcie_read_req_arbiter;
  localparam int CC = 16, CW = 4, TW = 9, MAXO = 4, DW = 16;
  logic pcie_clk = 1'b0;
  logic pcie_rst_n = 1'b0;
  logic enable = 1'b0;
  logic [CC*128-1:0] req_tdata;
  logic [CC-1:0] req_tvalid, req_tready;
  logic [127:0] m_tdata;
  logic [CW-1:0] m_tuser;
  logic m_tvalid, m_tready;
  logic [TW-1:0] rx_tdest;
  logic rx_tvalid, rx_tready, rx_tlast;
  logic [CC-1:0] core_busy;
  logic [DW-1:0] drop_count;
  logic credit_underflow;
  int n_cmp = 0, n_bad = 0;
  logic e_v, e_uf;
  logic [127:0] e_d;
  int e_u, ptr, drops;
  int cred [CC];
  logic [CC-1:0] exp_rdy, obs_rdy;

  always #5 pcie_clk = ~pcie_clk;

  pcie_read_req_arbiter dut (
    .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n), .enable(enable),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .rx_tdest(rx_tdest), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
    .core_busy(core_busy), .drop_count(drop_count), .credit_underflow(credit_underflow)
  );

  task automatic model_reset();
    e_v = 0; e_uf = 0; e_d = '0; e_u = 0; ptr = 0; drops = 0;
    for (int i = 0; i < CC; i++) cred[i] = 0;
  endtask

  task automatic idle();
    req_tvalid = '0; rx_tvalid = 0; rx_tready = 0; rx_tlast = 0; rx_tdest = '0;
  endtask

  task automatic set_req(input int i, input int len);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, 16'($urandom), 16'(len)};
    req_tdata[i*128 +: 128] = r;
    req_tvalid[i] = 1'b1;
  endtask

  task automatic completion(input int c);
    rx_tvalid = 1; rx_tready = 1; rx_tlast = 1;
    rx_tdest = {4'(c), 5'($urandom)};
  endtask

  task automatic do_reset();
    pcie_rst_n = 0;
    idle();
    model_reset();
    @(posedge pcie_clk);
    #1 pcie_rst_n = 1;
  endtask

  task automatic cycle();
    int g, i, c, oc;
    bit ld;
    @(negedge pcie_clk);
    obs_rdy = req_tready;
    ld = !e_v || m_tready;
    g = -1;
    for (int k = 0; k < CC; k++) begin
      i = (ptr + k) % CC;
      if (g < 0 && req_tvalid[i] && enable && (cred[i] < MAXO || req_tdata[i*128 +: 16] == 16'd0)) g = i;
    end
    exp_rdy = (ld && g >= 0) ? CC'(1) << g : '0;
    @(posedge pcie_clk);
    c = int'(rx_tdest) >> (TW - CW);
    oc = cred[c];
    if (ld) e_v = 0;
    if (ld && g >= 0) begin
      ptr = (g + 1) % CC;
      if (req_tdata[g*128 +: 16] == 16'd0) drops = (drops < 65535) ? drops + 1 : drops;
      else begin
        e_v = 1; e_d = req_tdata[g*128 +: 128]; e_u = g; cred[g]++;
      end
    end
    if (rx_tvalid && rx_tready && rx_tlast) begin
      if (oc == 0) e_uf = 1;
      cred[c] = (cred[c] > 0) ? cred[c] - 1 : 0;
    end
    #1;
  endtask

  task automatic test_reset();
    pcie_rst_n = 0; enable = 1; m_tready = 1;
    req_tvalid = CC'($urandom) | CC'(1);
    #3;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    n_cmp++; if (m_tdata !== '0 || m_tuser !== '0) begin n_bad++; $display("FAIL reset_data: got %h/%0d want 0/0", m_tdata, m_tuser); end
    n_cmp++; if (drop_count !== '0 || credit_underflow !== 1'b0) begin n_bad++; $display("FAIL reset_status: got %0d/%b want 0/0", drop_count, credit_underflow); end
    n_cmp++; if (core_busy !== '0) begin n_bad++; $display("FAIL reset_busy: got %h want 0", core_busy); end
    n_cmp++; if (req_tready !== '0) begin n_bad++; $display("FAIL reset_ready: got %h want 0", req_tready); end
    do_reset();
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 3, 7, 0, 3, 7};
    do_reset(); enable = 1; m_tready = 1;
    set_req(0, 64); set_req(3, 64); set_req(7, 64);
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_cmp++; if (obs_rdy !== CC'(1) << order[k]) begin n_bad++; $display("FAIL rr_ready[%0d]: got %h want %h", k, obs_rdy, CC'(1) << order[k]); end
      n_cmp++; if (m_tvalid !== 1'b1 || int'(m_tuser) != order[k]) begin n_bad++; $display("FAIL rr_user[%0d]: got v=%b u=%0d want v=1 u=%0d", k, m_tvalid, m_tuser, order[k]); end
      n_cmp++; if (m_tdata !== e_d) begin n_bad++; $display("FAIL rr_data[%0d]: got %h want %h", k, m_tdata, e_d); end
    end
    idle();
  endtask

  task automatic test_credit_limit();
    int fwd = 0;
    do_reset(); enable = 1; m_tready = 1;
    set_req(2, 8);
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (m_tvalid) fwd++;
    end
    n_cmp++; if (fwd != MAXO) begin n_bad++; $display("FAIL credit_fwd: got %0d want %0d", fwd, MAXO); end
    n_cmp++; if (obs_rdy[2] !== 1'b0 || core_busy[2] !== 1'b1) begin n_bad++; $display("FAIL credit_stall: got rdy=%b busy=%b want 0/1", obs_rdy[2], core_busy[2]); end
    completion(2);
    cycle();
    n_cmp++; if (obs_rdy[2] !== 1'b0 || core_busy[2] !== 1'b0) begin n_bad++; $display("FAIL credit_return: got rdy=%b busy=%b want 0/0", obs_rdy[2], core_busy[2]); end
    rx_tvalid = 0;
    cycle();
    n_cmp++; if (obs_rdy[2] !== 1'b1 || m_tvalid !== 1'b1 || m_tuser !== 4'd2) begin n_bad++; $display("FAIL credit_resume: got rdy=%b v=%b u=%0d want 1/1/2", obs_rdy[2], m_tvalid, m_tuser); end
    n_cmp++; if (core_busy[2] !== 1'b1) begin n_bad++; $display("FAIL credit_rebusy: got %b want 1", core_busy[2]); end
    idle();
  endtask

  task automatic test_backpressure();
    logic [127:0] want;
    do_reset(); enable = 1; m_tready = 1;
    set_req(1, 32); set_req(4, 32);
    want = req_tdata[1*128 +: 128];
    cycle();
    m_tready = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      n_cmp++; if (obs_rdy !== '0 || m_tvalid !== 1'b1 || m_tdata !== want || m_tuser !== 4'd1) begin n_bad++; $display("FAIL hold[%0d]: got rdy=%h v=%b u=%0d d=%h want 0/1/1/%h", k, obs_rdy, m_tvalid, m_tuser, m_tdata, want); end
    end
    m_tready = 1;
    cycle();
    n_cmp++; if (obs_rdy !== CC'(1) << 4 || m_tuser !== 4'd4 || m_tvalid !== 1'b1) begin n_bad++; $display("FAIL release: got rdy=%h u=%0d v=%b want %h/4/1", obs_rdy, m_tuser, m_tvalid, CC'(1) << 4); end
    cycle();
    n_cmp++; if (m_tuser !== 4'd1 || m_tdata !== e_d) begin n_bad++; $display("FAIL release_next: got u=%0d want 1", m_tuser); end
    idle();
  endtask

  task automatic test_zero_length();
    do_reset(); enable = 1; m_tready = 1;
    set_req(5, 0);
    cycle();
    n_cmp++; if (obs_rdy !== CC'(1) << 5) begin n_bad++; $display("FAIL zl_ready: got %h want %h", obs_rdy, CC'(1) << 5); end
    n_cmp++; if (m_tvalid !== 1'b0 || drop_count !== 16'd1) begin n_bad++; $display("FAIL zl_drop: got v=%b drop=%0d want 0/1", m_tvalid, drop_count); end
    set_req(5, 16);
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (k >= 2) begin
        n_cmp++; if (core_busy[5] !== (k == 3)) begin n_bad++; $display("FAIL zl_credit[%0d]: got busy=%b want %b", k, core_busy[5], k == 3); end
      end
    end
    n_cmp++; if (drop_count !== 16'd1) begin n_bad++; $display("FAIL zl_count: got %0d want 1", drop_count); end
    idle();
  endtask

  task automatic test_completion_collision();
    do_reset(); enable = 1; m_tready = 1;
    set_req(1, 16);
    cycle(); cycle();
    completion(1);
    cycle();
    n_cmp++; if (obs_rdy !== CC'(1) << 1) begin n_bad++; $display("FAIL coll_grant: got %h want %h", obs_rdy, CC'(1) << 1); end
    rx_tvalid = 0;
    cycle();
    n_cmp++; if (core_busy[1] !== 1'b0) begin n_bad++; $display("FAIL coll_net3: got busy=%b want 0", core_busy[1]); end
    cycle();
    n_cmp++; if (core_busy[1] !== 1'b1) begin n_bad++; $display("FAIL coll_net4: got busy=%b want 1", core_busy[1]); end
    idle();
    n_cmp++; if (credit_underflow !== 1'b0) begin n_bad++; $display("FAIL uf_pre: got %b want 0", credit_underflow); end
    completion(9);
    cycle();
    n_cmp++; if (credit_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_set: got %b want 1", credit_underflow); end
    rx_tvalid = 0;
    set_req(9, 16);
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (k >= 2) begin
        n_cmp++; if (core_busy[9] !== (k == 3)) begin n_bad++; $display("FAIL uf_credit[%0d]: got busy=%b want %b", k, core_busy[9], k == 3); end
      end
    end
    idle();
  endtask

  task automatic test_random();
    int c;
    logic [CC-1:0] eb;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      enable = $urandom_range(0, 9) != 0;
      m_tready = $urandom_range(0, 3) != 0;
      for (int i = 0; i < CC; i++) begin
        if ($urandom_range(0, 2) == 0) set_req(i, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4096));
        else req_tvalid[i] = 1'b0;
      end
      c = $urandom_range(0, CC - 1);
      if ($urandom_range(0, 15) != 0)
        for (int k = 0; k < CC && cred[c] == 0; k++) c = (c + 1) % CC;
      completion(c);
      rx_tvalid = $urandom_range(0, 1); rx_tready = $urandom_range(0, 3) != 0; rx_tlast = $urandom_range(0, 1);
      cycle();
      for (int i = 0; i < CC; i++) eb[i] = cred[i] == MAXO;
      n_cmp++; if (obs_rdy !== exp_rdy) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %h want %h", n, obs_rdy, exp_rdy); end
      n_cmp++; if (m_tvalid !== e_v) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, m_tvalid, e_v); end
      if (e_v) begin
        n_cmp++; if (int'(m_tuser) != e_u || m_tdata !== e_d) begin n_bad++; $display("FAIL rnd_out[%0d]: got u=%0d d=%h want u=%0d d=%h", n, m_tuser, m_tdata, e_u, e_d); end
      end
      n_cmp++; if (core_busy !== eb) begin n_bad++; $display("FAIL rnd_busy[%0d]: got %h want %h", n, core_busy, eb); end
      n_cmp++; if (drop_count !== DW'(drops) || credit_underflow !== e_uf) begin n_bad++; $display("FAIL rnd_status[%0d]: got %0d/%b want %0d/%b", n, drop_count, credit_underflow, drops, e_uf); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset(); enable = 1; m_tready = 1;
    set_req(0, 16); set_req(5, 16);
    cycle(); cycle();
    #2 pcie_rst_n = 0;
    #1;
    model_reset();
    n_cmp++; if (m_tvalid !== 1'b0 || core_busy !== '0 || req_tready !== '0) begin n_bad++; $display("FAIL arst_clear: got v=%b busy=%h rdy=%h want 0/0/0", m_tvalid, core_busy, req_tready); end
    @(posedge pcie_clk);
    #1 pcie_rst_n = 1;
    cycle();
    n_cmp++; if (obs_rdy !== CC'(1) || m_tuser !== 4'd0 || m_tvalid !== 1'b1) begin n_bad++; $display("FAIL arst_restart: got rdy=%h u=%0d v=%b want 0001/0/1", obs_rdy, m_tuser, m_tvalid); end
    req_tvalid = '0;
    completion(5);
    cycle();
    n_cmp++; if (credit_underflow !== 1'b1) begin n_bad++; $display("FAIL arst_uf: got %b want 1", credit_underflow); end
    idle();
  endtask

  initial begin
    req_tdata = '0; req_tvalid = '0; m_tready = 0;
    rx_tdest = '0; rx_tvalid = 0; rx_tready = 0; rx_tlast = 0;
    model_reset();
    test_reset();
    test_round_robin();
    test_credit_limit();
    test_backpressure();
    test_zero_length();
    test_completion_collision();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pcie_read_req_arbiter.md
Name: pcie_read_req_arbiter

Overview:
- Shares the single core-request channel of the PCIe continuous-read engine between CORE_COUNT cores.
- Each core presents 128-bit read requests:
  - bits [15:0] length
  - bits [31:16] core tag
  - bits [63:32] core address
  - bits [127:64] host PCIe address
- Grants requests round-robin and forwards them through a one-entry register stage to the engine's cores_ctrl_s input, with tuser carrying the core index.
- Limits in-flight reads per core with credit counters. Credits are returned by snooping tlast beats on the engine's cores_rx output.

Parameters:
- CORE_COUNT, 16, number of requesting cores
- CORE_WIDTH, $clog2(CORE_COUNT), core index width
- AXIS_TAG_WIDTH, 9, width of the cores_rx tdest; the core index is in its upper CORE_WIDTH bits
- MAX_OUTSTANDING, 4, maximum in-flight reads per core (≥1)
- CREDIT_WIDTH, $clog2(MAX_OUTSTANDING+1), width of the per-core credit counter
- DROP_CNT_WIDTH, 16, width of the zero-length drop counter

Ports:
- pcie_clk  in  1  clock
- pcie_rst_n  in  1  asynchronous active-low reset
- enable  in  1  when low, no new grants are issued
- req_tdata  in  CORE_COUNT*128  per-core request; core i uses bits [i*128 +: 128]
- req_tvalid  in  CORE_COUNT  per-core request valid
- req_tready  out  CORE_COUNT  per-core accept; one-hot or zero
- m_tdata  out  128  forwarded request
- m_tuser  out  CORE_WIDTH  index of the originating core
- m_tvalid  out  1  forwarded request valid
- m_tready  in  1  engine accepts the request
- rx_tdest  in  AXIS_TAG_WIDTH  snooped engine output tdest
- rx_tvalid  in  1  snooped valid
- rx_tready  in  1  snooped ready
- rx_tlast  in  1  snooped last
- core_busy  out  CORE_COUNT  bit i set when core i's credit equals MAX_OUTSTANDING
- drop_count  out  DROP_CNT_WIDTH  saturating count of dropped zero-length requests
- credit_underflow  out  1  sticky flag: a completion arrived for a core with zero credits

Behaviour:
- Reset (async assert, synchronous release): m_tvalid=0, m_tdata=0, m_tuser=0, all credits=0, RR pointer=0, drop_count=0, credit_underflow=0, core_busy=0. req_tready is combinational and is 0 while in reset.
- Eligibility: core i is eligible when req_tvalid[i] && (credit[i] < MAX_OUTSTANDING || len==0) && enable.
- Load: load = !m_tvalid || m_tready.
- Grant: g = first eligible core searching from pointer upward, wrapping at CORE_COUNT-1 to 0. req_tready[g] = load && any_eligible; all other req_tready bits are 0.
- Grant, non-zero length:
  - On the next edge: m_tdata <= req_tdata[g], m_tuser <= g, m_tvalid <= 1, credit[g] += 1.
  - Latency from accept to m_tvalid is 1 cycle.
  - Full throughput: back-to-back grants are possible while m_tready stays high.
- Grant, zero length (len==0):
  - Request is accepted and discarded.
  - No m_tvalid, no credit change.
  - drop_count += 1, saturating at all-ones.
  - m_tvalid <= 0 when the stage was emptied on the same cycle.
- RR pointer: after any grant, pointer <= (g+1) mod CORE_COUNT. The pointer is unchanged when there is no grant.
- Output hold: while m_tvalid && !m_tready, m_tdata/m_tuser/m_tvalid are held stable and there are no grants. m_tvalid <= 0 when m_tready && no grant.
- Completion: on rx_tvalid && rx_tready && rx_tlast, c = rx_tdest[AXIS_TAG_WIDTH-1 -: CORE_WIDTH] and credit[c] -= 1.
  - If credit[c]==0: the counter stays 0 and credit_underflow <= 1 (cleared only by reset).
- Simultaneous increment and decrement on the same core: net zero change. On different cores, both are applied.
- enable deasserted:
  - A held output still completes.
  - Completions are still counted.
  - Grants resume the cycle after enable returns high.
- core_busy is registered from the credit values (same cycle as the credit update).
- Reset mid-operation: a pending m_tvalid is dropped and credits are cleared. Completions arriving after reset for pre-reset requests set credit_underflow.

Decomposition:
- Package pcie_read_pkg holds:
  - request field offsets/widths: LEN [15:0], CORE_TAG [31:16], CORE_ADDR [63:32], HOST_ADDR [127:64]
  - REQ_WIDTH=128
  - the helper that extracts the core index from tdest
- Sub-module rr_arbiter(N): combinational masked-priority select of the request vector with the pointer, returning the one-hot grant, encoded index and any_valid. The pointer register stays in the parent.

Test Plan:
- Cores 0, 3 and 7 hold valid requests continuously with len=64 and m_tready=1 -> grant order 0,3,7,0,3,7; m_tuser matches; one m_tvalid per cycle.
- Core 2 issues 5 requests with MAX_OUTSTANDING=4 and no completions -> 4 forwarded; the fifth stalls with req_tready[2]=0 and core_busy[2]=1. One rx tlast beat with tdest upper bits=2 -> the fifth is forwarded 1 cycle later.
- m_tready held low for 10 cycles with requests pending -> m_tdata stable and no req_tready. Release -> the held request is accepted, then the next grant follows.
- Core 5 request with len=0 -> req_tready[5]=1, no m_tvalid, drop_count=1, credit[5] unchanged.
- Completion for core 1 in the same cycle core 1 is granted, with credit 2 -> credit stays 2. Completion for core 9 with credit 0 -> credit_underflow=1 and the credit stays 0.
- Reset asserted asynchronously mid-burst with m_tvalid=1 -> m_tvalid=0 immediately and all credits 0; after release, grant restarts from core 0.
